// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: redirect select encodings, NOP word and
// the fetch FSM state type.
package mips_pkg;

  localparam logic [1:0]  PCSRC_SEQ  = 2'b00;
  localparam logic [1:0]  PCSRC_BR   = 2'b01;
  localparam logic [1:0]  PCSRC_JMP  = 2'b10;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/MUX_2_to_1.sv
// Generic two-input multiplexer: y = sel ? d1 : d0.
module MUX_2_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register. Priority: flush, then stall (hold), then load,
// otherwise a bubble is inserted.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             load,
  input  logic [WIDTH-1:0] next_instr,
  input  logic [WIDTH-1:0] next_pc_plus4,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid
);

  // Flush and bubble only clear the instruction/valid; PC+4 is left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= WIDTH'(NOP_INSTR);
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= WIDTH'(NOP_INSTR);
      valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr    <= next_instr;
        pc_plus4 <= next_pc_plus4;
        valid    <= 1'b1;
      end else begin
        instr <= WIDTH'(NOP_INSTR);
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, single-outstanding req/gnt/valid fetch from
// instruction memory, and the IF/ID register with stall/flush.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               PCSrcD_width = 2,
  parameter logic [WIDTH-1:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [PCSrcD_width-1:0] PCSrcD,
  input  logic [WIDTH-1:0]        PCBranchD,
  input  logic                    StallF,
  input  logic                    StallD,
  input  logic                    FlushD,
  output logic                    IMemReq,
  output logic [WIDTH-1:0]        IMemAddr,
  input  logic                    IMemGnt,
  input  logic                    IMemValid,
  input  logic [WIDTH-1:0]        IMemRdata,
  output logic [WIDTH-1:0]        PCF,
  output logic [WIDTH-1:0]        InstrD,
  output logic [WIDTH-1:0]        PCPlus4D,
  output logic                    ValidD
);

  fetch_state_t     state, state_next;
  logic [WIDTH-1:0] pc_plus4_f, req_pc, hold_instr;
  logic [WIDTH-1:0] jump_target, redirect_target, pc_seq, pc_next;
  logic             redirect, req_ok, granted;
  logic             take_resp, take_hold, consumed;

  assign redirect    = (PCSrcD != PCSrcD_width'(PCSRC_SEQ)) && !StallD;
  assign pc_plus4_f  = PCF + WIDTH'(WORD_BYTES);
  assign jump_target = {PCPlus4D[WIDTH-1:28], InstrD[25:0], 2'b00};

  // A redirect keeps the request up even while StallF is asserted.
  assign req_ok   = (state == S_REQ) && !RST && !(StallF && !redirect);
  assign granted  = req_ok && IMemGnt;
  assign IMemReq  = req_ok;
  assign IMemAddr = PCF;
  assign consumed = take_resp || take_hold;

  MUX_2_to_1 #(.WIDTH(WIDTH)) u_target_mux (
    .d0  (PCBranchD),
    .d1  (jump_target),
    .sel (PCSrcD[PCSrcD_width-1]),
    .y   (redirect_target)
  );

  assign pc_seq = (consumed && !StallF) ? pc_plus4_f : PCF;

  MUX_2_to_1 #(.WIDTH(WIDTH)) u_pc_mux (
    .d0  (pc_seq),
    .d1  (redirect_target),
    .sel (redirect),
    .y   (pc_next)
  );

  always_comb begin
    state_next = state;
    take_resp  = 1'b0;
    take_hold  = 1'b0;
    case (state)
      S_REQ: begin
        if (granted) state_next = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (IMemValid) begin
          if (redirect) begin
            state_next = S_REQ;
          end else if (!StallD) begin
            take_resp  = 1'b1;
            state_next = S_REQ;
          end else begin
            state_next = S_HOLD;
          end
        end else if (redirect) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (IMemValid) state_next = S_REQ;
      end
      S_HOLD: begin
        // With StallD low any non-zero PCSrcD is a redirect that discards the buffer.
        if (!StallD) begin
          take_hold  = !redirect;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_REQ;
      PCF        <= RESET_PC;
      req_pc     <= '0;
      hold_instr <= '0;
    end else begin
      state <= state_next;
      PCF   <= pc_next;
      if (granted) req_pc <= PCF;
      if (state == S_WAIT && state_next == S_HOLD) hold_instr <= IMemRdata;
    end
  end

  ifid_reg #(.WIDTH(WIDTH)) u_ifid (
    .clk           (CLK),
    .rst           (RST),
    .flush         (FlushD || redirect),
    .stall         (StallD),
    .load          (consumed),
    .next_instr    (take_hold ? hold_instr : IMemRdata),
    .next_pc_plus4 (req_pc + WIDTH'(WORD_BYTES)),
    .instr         (InstrD),
    .pc_plus4      (PCPlus4D),
    .valid         (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  PCSrcD;
  logic [31:0] PCBranchD;
  logic        StallF, StallD, FlushD;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt, IMemValid;
  logic [31:0] IMemRdata;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.WIDTH(32), .PCSrcD_width(2), .RESET_PC(32'h0000_0000)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemGnt   (IMemGnt),
    .IMemValid (IMemValid),
    .IMemRdata (IMemRdata),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs;
    PCSrcD = 2'b00; PCBranchD = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    IMemGnt = 1'b0; IMemValid = 1'b0; IMemRdata = '0;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One grant cycle followed by a one-cycle-latency response.
  task automatic fetch_word(input logic [31:0] w);
    IMemGnt = 1'b1; tick(); IMemGnt = 1'b0;
    IMemValid = 1'b1; IMemRdata = w; tick(); IMemValid = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic test_reset;
    idle_inputs(); RST = 1'b1;
    tick(); tick();
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL rst_pcf got=%h exp=%h", PCF, 32'h0); end
    checks++; if (InstrD !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=%h", InstrD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=%h", PCPlus4D, 32'h0); end
    checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ValidD); end
    checks++; if (IMemReq !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", IMemReq); end
    RST = 1'b0; #1;
    checks++; if (IMemReq !== 1'b1) begin failures++; $display("FAIL rst_req_release got=%b exp=1", IMemReq); end
    IMemGnt = 1'b1; tick(); IMemGnt = 1'b0;
    RST = 1'b1; #1;
    checks++; if (IMemReq !== 1'b0) begin failures++; $display("FAIL rst_mid_wait_req got=%b exp=0", IMemReq); end
    IMemValid = 1'b1; IMemRdata = 32'hDEAD_BEEF;
    tick();
    RST = 1'b0; #1;
    checks++; if (IMemReq !== 1'b1) begin failures++; $display("FAIL rst_req_again got=%b exp=1", IMemReq); end
    tick();
    IMemValid = 1'b0;
    checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL rst_stale_valid got=%b exp=0", ValidD); end
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL rst_stale_pcf got=%h exp=%h", PCF, 32'h0); end
  endtask

  task automatic test_sequential;
    fetch_word(32'h2008_0005);
    checks++; if (InstrD !== 32'h2008_0005) begin failures++; $display("FAIL seq_instr1 got=%h exp=%h", InstrD, 32'h2008_0005); end
    checks++; if (PCPlus4D !== 32'h4) begin failures++; $display("FAIL seq_pc4_1 got=%h exp=%h", PCPlus4D, 32'h4); end
    checks++; if (ValidD !== 1'b1) begin failures++; $display("FAIL seq_valid1 got=%b exp=1", ValidD); end
    checks++; if (PCF !== 32'h4) begin failures++; $display("FAIL seq_pcf1 got=%h exp=%h", PCF, 32'h4); end
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin failures++; $display("FAIL seq_req1 got=%b/%h exp=1/%h", IMemReq, IMemAddr, 32'h4); end
    fetch_word(32'h2009_0003);
    checks++; if (InstrD !== 32'h2009_0003) begin failures++; $display("FAIL seq_instr2 got=%h exp=%h", InstrD, 32'h2009_0003); end
    checks++; if (PCPlus4D !== 32'h8) begin failures++; $display("FAIL seq_pc4_2 got=%h exp=%h", PCPlus4D, 32'h8); end
    checks++; if (PCF !== 32'h8) begin failures++; $display("FAIL seq_pcf2 got=%h exp=%h", PCF, 32'h8); end
  endtask

  task automatic test_branch;
    IMemGnt = 1'b1; tick(); IMemGnt = 1'b0;
    PCSrcD = 2'b01; PCBranchD = 32'h40; #1;
    checks++; if (IMemReq !== 1'b0) begin failures++; $display("FAIL br_wait_req got=%b exp=0", IMemReq); end
    tick(); PCSrcD = 2'b00;
    checks++; if (PCF !== 32'h40) begin failures++; $display("FAIL br_pcf got=%h exp=%h", PCF, 32'h40); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin failures++; $display("FAIL br_flush got=%b/%h exp=0/0", ValidD, InstrD); end
    IMemValid = 1'b1; IMemRdata = 32'h8BAD_F00D; #1;
    checks++; if (IMemReq !== 1'b0) begin failures++; $display("FAIL br_drop_req got=%b exp=0", IMemReq); end
    tick(); IMemValid = 1'b0; #1;
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin failures++; $display("FAIL br_discard got=%b/%h exp=0/0", ValidD, InstrD); end
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h40) begin failures++; $display("FAIL br_next_addr got=%b/%h exp=1/%h", IMemReq, IMemAddr, 32'h40); end
  endtask

  task automatic test_jump;
    PCSrcD = 2'b01; PCBranchD = 32'h0; tick(); PCSrcD = 2'b00;
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL jmp_setup_pcf got=%h exp=%h", PCF, 32'h0); end
    fetch_word(32'h0800_0010);
    checks++; if (InstrD !== 32'h0800_0010 || PCPlus4D !== 32'h4) begin failures++; $display("FAIL jmp_setup_ifid got=%h/%h exp=%h/%h", InstrD, PCPlus4D, 32'h0800_0010, 32'h4); end
    PCSrcD = 2'b10; tick(); PCSrcD = 2'b00;
    checks++; if (IMemAddr !== 32'h40) begin failures++; $display("FAIL jmp_addr got=%h exp=%h", IMemAddr, 32'h40); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin failures++; $display("FAIL jmp_flush got=%b/%h exp=0/0", ValidD, InstrD); end
  endtask

  task automatic test_stall;
    fetch_word(32'h1111_2222);
    checks++; if (InstrD !== 32'h1111_2222 || PCPlus4D !== 32'h44) begin failures++; $display("FAIL stall_setup got=%h/%h exp=%h/%h", InstrD, PCPlus4D, 32'h1111_2222, 32'h44); end
    StallD = 1'b1; IMemGnt = 1'b1; tick(); IMemGnt = 1'b0;
    StallF = 1'b1; IMemValid = 1'b1; IMemRdata = 32'h3333_4444; tick(); IMemValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (InstrD !== 32'h1111_2222 || ValidD !== 1'b1) begin failures++; $display("FAIL stall_hold_ifid[%0d] got=%h/%b exp=%h/1", i, InstrD, ValidD, 32'h1111_2222); end
      checks++; if (PCF !== 32'h44 || IMemReq !== 1'b0) begin failures++; $display("FAIL stall_hold_pc[%0d] got=%h/%b exp=%h/0", i, PCF, IMemReq, 32'h44); end
      if (i < 2) tick();
    end
    StallD = 1'b0; StallF = 1'b0; tick();
    checks++; if (InstrD !== 32'h3333_4444 || ValidD !== 1'b1) begin failures++; $display("FAIL stall_release got=%h/%b exp=%h/1", InstrD, ValidD, 32'h3333_4444); end
    checks++; if (PCPlus4D !== 32'h48 || PCF !== 32'h48) begin failures++; $display("FAIL stall_release_pc got=%h/%h exp=%h/%h", PCPlus4D, PCF, 32'h48, 32'h48); end
    tick();
    checks++; if (PCF !== 32'h48 || ValidD !== 1'b0) begin failures++; $display("FAIL stall_once got=%h/%b exp=%h/0", PCF, ValidD, 32'h48); end
  endtask

  task automatic test_grant_delay;
    for (int i = 0; i < 4; i++) begin
      checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h48) begin failures++; $display("FAIL gnt_wait_req[%0d] got=%b/%h exp=1/%h", i, IMemReq, IMemAddr, 32'h48); end
      tick();
      checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL gnt_wait_bubble[%0d] got=%b exp=0", i, ValidD); end
    end
    IMemGnt = 1'b1; tick(); IMemGnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ValidD !== 1'b0 || PCF !== 32'h48) begin failures++; $display("FAIL gnt_lat_bubble[%0d] got=%b/%h exp=0/%h", i, ValidD, PCF, 32'h48); end
    end
    IMemValid = 1'b1; IMemRdata = 32'h5555_6666; tick(); IMemValid = 1'b0;
    checks++; if (InstrD !== 32'h5555_6666 || ValidD !== 1'b1) begin failures++; $display("FAIL gnt_load got=%h/%b exp=%h/1", InstrD, ValidD, 32'h5555_6666); end
    checks++; if (PCPlus4D !== 32'h4C || PCF !== 32'h4C) begin failures++; $display("FAIL gnt_load_pc got=%h/%h exp=%h/%h", PCPlus4D, PCF, 32'h4C, 32'h4C); end
  endtask

  task automatic test_wrap;
    PCSrcD = 2'b01; PCBranchD = 32'hFFFF_FFFC; tick(); PCSrcD = 2'b00;
    checks++; if (PCF !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=%h", PCF, 32'hFFFF_FFFC); end
    fetch_word(32'h7777_8888);
    checks++; if (PCPlus4D !== 32'h0 || InstrD !== 32'h7777_8888) begin failures++; $display("FAIL wrap_pc4 got=%h/%h exp=%h/%h", PCPlus4D, InstrD, 32'h0, 32'h7777_8888); end
    checks++; if (IMemAddr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", IMemAddr, 32'h0); end
    IMemGnt = 1'b1; tick(); IMemGnt = 1'b0;
    IMemValid = 1'b1; IMemRdata = 32'h9999_AAAA; PCSrcD = 2'b01; PCBranchD = 32'h100; FlushD = 1'b1;
    tick();
    IMemValid = 1'b0; PCSrcD = 2'b00; FlushD = 1'b0; #1;
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin failures++; $display("FAIL redir_flush_discard got=%b/%h exp=0/0", ValidD, InstrD); end
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h100) begin failures++; $display("FAIL redir_flush_next got=%b/%h exp=1/%h", IMemReq, IMemAddr, 32'h100); end
  endtask

  // Reference model tracks the outstanding request, the hold buffer and the
  // IF/ID contents as transactions; memory answers 1..3 cycles after a grant.
  task automatic test_random;
    logic [31:0] m_pc, m_out_pc, m_buf_word, m_buf_pc, m_instr, m_pc4;
    logic        m_out, m_drop, m_buf, m_valid;
    logic [31:0] n_pc, n_out_pc, n_buf_word, n_buf_pc, n_instr, n_pc4;
    logic        n_out, n_drop, n_buf, n_valid;
    logic [31:0] tgt, take_word, take_pc4, busy_word;
    logic        redir, req, arrive, take, rst_now;
    int          busy;

    idle_inputs(); RST = 1'b1; tick(); RST = 1'b0;
    m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_out_pc = '0; m_buf = 1'b0;
    m_buf_word = '0; m_buf_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    busy = 0; busy_word = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_now = (cyc == 1500);
      RST     = rst_now;
      StallF  = ($urandom_range(0, 5) == 0);
      StallD  = ($urandom_range(0, 5) == 0);
      FlushD  = ($urandom_range(0, 11) == 0);
      PCBranchD = $urandom() & 32'h0000_3FFC;
      case ($urandom_range(0, 11))
        0:       PCSrcD = 2'b01;
        1:       PCSrcD = m_valid ? 2'($urandom_range(2, 3)) : 2'b00;
        default: PCSrcD = 2'b00;
      endcase
      IMemValid = (busy == 1);
      IMemRdata = IMemValid ? busy_word : $urandom();
      redir = (PCSrcD != 2'b00) && !StallD;
      req   = !rst_now && !m_out && !m_buf && !(StallF && !redir);
      IMemGnt = req && (busy == 0) && ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (IMemReq !== req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, IMemReq, req); end
      if (req) begin
        checks++; if (IMemAddr !== m_pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, IMemAddr, m_pc); end
      end

      tgt    = PCSrcD[1] ? {m_pc4[31:28], m_instr[25:0], 2'b00} : PCBranchD;
      arrive = m_out && IMemValid;
      take = 1'b0; take_word = '0; take_pc4 = '0;
      if (arrive && !m_drop && !redir && !StallD) begin
        take = 1'b1; take_word = IMemRdata; take_pc4 = m_out_pc + 32'd4;
      end else if (m_buf && !StallD && !redir) begin
        take = 1'b1; take_word = m_buf_word; take_pc4 = m_buf_pc + 32'd4;
      end
      n_pc = redir ? tgt : ((take && !StallF) ? m_pc + 32'd4 : m_pc);
      n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
      if (FlushD || redir) begin
        n_instr = '0; n_valid = 1'b0;
      end else if (!StallD) begin
        if (take) begin
          n_instr = take_word; n_pc4 = take_pc4; n_valid = 1'b1;
        end else begin
          n_instr = '0; n_valid = 1'b0;
        end
      end
      n_buf = m_buf ? StallD : (arrive && !m_drop && !redir && StallD);
      n_buf_word = m_buf_word; n_buf_pc = m_buf_pc;
      if (!m_buf && n_buf) begin
        n_buf_word = IMemRdata; n_buf_pc = m_out_pc;
      end
      n_out = m_out && !arrive; n_drop = m_drop || (m_out && redir); n_out_pc = m_out_pc;
      if (IMemGnt) begin
        n_out = 1'b1; n_out_pc = m_pc; n_drop = redir;
      end
      if (!n_out) n_drop = 1'b0;
      if (rst_now) begin
        n_pc = '0; n_out = 1'b0; n_drop = 1'b0; n_buf = 1'b0;
        n_instr = '0; n_pc4 = '0; n_valid = 1'b0;
      end

      if (busy > 0) busy--;
      if (IMemGnt) begin
        busy = $urandom_range(1, 3); busy_word = mem_word(m_pc);
      end

      tick();
      RST = 1'b0;
      m_pc = n_pc; m_out = n_out; m_drop = n_drop; m_out_pc = n_out_pc;
      m_buf = n_buf; m_buf_word = n_buf_word; m_buf_pc = n_buf_pc;
      m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;

      checks++; if (PCF !== m_pc) begin failures++; $display("FAIL rnd_pcf cyc=%0d got=%h exp=%h", cyc, PCF, m_pc); end
      checks++; if (ValidD !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, ValidD, m_valid); end
      checks++; if (InstrD !== m_instr) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", cyc, InstrD, m_instr); end
      if (m_valid) begin
        checks++; if (PCPlus4D !== m_pc4) begin failures++; $display("FAIL rnd_pc4 cyc=%0d got=%h exp=%h", cyc, PCPlus4D, m_pc4); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_grant_delay();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline; the producer side of the IF/ID interface that Decode consumes (InstrD, PCPlus4D) and the consumer of Decode's redirect outputs (PCSrcD, PCBranchD).
- Owns the PC register and a single-outstanding request/grant/valid handshake to instruction memory.
- Owns the IF/ID pipeline register with stall and flush support.

Parameters:
- WIDTH, 32, data/address width.
- PCSrcD_width, 2, redirect select width.
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] must be 0.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- PCSrcD  in  2  redirect select: 00 = sequential, 01 = branch, 1x = jump (jump has priority).
- PCBranchD  in  32  branch target from Decode.
- StallF  in  1  hazard unit: hold PC, issue no new request.
- StallD  in  1  hazard unit: hold the IF/ID register and ignore PCSrcD.
- FlushD  in  1  hazard unit: clear the IF/ID register.
- IMemReq  out  1  instruction memory request; held high until granted.
- IMemAddr  out  32  request address; always equals PCF.
- IMemGnt  in  1  request accepted this cycle.
- IMemValid  in  1  response valid; earliest one cycle after the grant.
- IMemRdata  in  32  instruction word.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction; 0 (nop) when invalid.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values: PCF = RESET_PC; InstrD = 0; PCPlus4D = 0; ValidD = 0; state = S_REQ; IMemReq = 0 during reset and high the first cycle after release.
- Reset asserted mid-transaction abandons the request. Any IMemValid received before the first post-reset grant is ignored.
- PCPlus4F = PCF + 4, mod 2^32 (wraps from 32'hFFFF_FFFC to 0).
- Jump target = {PCPlus4D[31:28], InstrD[25:0], 2'b00}, computed internally from the IF/ID register.
- Redirect accepted when PCSrcD != 00 and StallD = 0. Redirect overrides StallF.
- Next PC:
  - redirect: jump target or PCBranchD;
  - else if the instruction is consumed (response or buffer moves into IF/ID) and StallF = 0: PCPlus4F;
  - else hold.
- FSM transitions:
  - S_REQ: IMemReq = 1. If IMemGnt and no redirect: S_WAIT. If IMemGnt and redirect in the same cycle: S_DROP. If no grant and redirect: stay in S_REQ with the new PCF (address may change only while ungranted). If StallF and no redirect: IMemReq = 0 and stay.
  - S_WAIT: on IMemValid:
    - redirect: discard the word, go to S_REQ;
    - StallD = 0: load IF/ID, go to S_REQ;
    - StallD = 1: capture the word in a hold buffer, go to S_HOLD.
    - Without IMemValid, a redirect moves the FSM to S_DROP.
  - S_DROP: wait for IMemValid, discard the word, go to S_REQ. PCF already holds the target.
  - S_HOLD: on StallD = 0, move the buffer into IF/ID and go to S_REQ. On redirect, discard the buffer and go to S_REQ.
- IF/ID register, in priority order:
  - FlushD or accepted redirect: cleared (InstrD = 0, ValidD = 0). This squashes the slot after a taken branch or jump.
  - else StallD: hold.
  - else load instruction: InstrD = word, PCPlus4D = PC of that word + 4, ValidD = 1.
  - else bubble: InstrD = 0, ValidD = 0.
- Latency: grant in cycle N, valid in cycle N+k; IF/ID is updated at the end of cycle N+k.
- The PC of an outstanding request is kept in a register so PCPlus4D is correct even if PCF is redirected.
- At most one request is outstanding at any time.

Decomposition:
- Shared package (mips_pkg): PCSRC_SEQ/PCSRC_BR/PCSRC_JMP encodings, NOP_INSTR = 32'h0, WORD_BYTES = 4, and the fetch FSM state typedef (S_REQ, S_WAIT, S_DROP, S_HOLD).
- Sub-module: ifid_reg (IF/ID pipeline register with load/stall/flush). Reuse the existing MUX_2_to_1 for the PC select.

Test Plan:
- Reset with RST = 1 mid-WAIT, then release, zero-latency grant, 1-cycle valid, words 0x20080005 / 0x20090003 -> PCF goes 0 -> 4 -> 8; InstrD = 0x20080005 with PCPlus4D = 4, ValidD = 1; then InstrD = 0x20090003 with PCPlus4D = 8.
- Branch: PCSrcD = 01, PCBranchD = 0x40 while a request for 0x8 is in S_WAIT -> S_DROP; the 0x8 word is discarded; ValidD = 0 next cycle; the next IMemAddr is 0x40.
- Jump: InstrD = 0x08000010, PCPlus4D = 0x4, PCSrcD = 10 -> next IMemAddr = 0x00000040; IF/ID flushed.
- StallD = 1 for 3 cycles when the response arrives -> S_HOLD; InstrD is unchanged during the stall; the held word loads on the cycle after StallD falls; PCF advances exactly once.
- IMemGnt low for 4 cycles, then valid after 3 more cycles -> IMemReq stays high with a constant IMemAddr; ValidD = 0 bubbles throughout; then one correct load.
- PCF = 0xFFFFFFFC with sequential fetch -> PCPlus4D = 0; next IMemAddr = 0. Redirect and FlushD in the same cycle as IMemValid -> the word is discarded and ValidD = 0.
